// File: rtl/banked_mem.sv
// Multi-port, multi-bank SRAM model: address-interleaved banks, per-bank round-robin
// arbitration and fixed-latency reads. Optional zero-sweep on reset: BANKED_MEM_CLEAR_EN.
module banked_mem #(
    parameter int    WIDTH     = 32,
    parameter int    DEPTH     = 256,
    parameter int    NUM_BANKS = 4,
    parameter int    NUM_PORTS = 2,
    parameter int    READ_LAT  = 1,
    parameter string MEM_FILE  = ""
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUM_PORTS-1:0]                      req_valid_i,
    output logic [NUM_PORTS-1:0]                      req_ready_o,
    input  logic [NUM_PORTS-1:0]                      req_we_i,
    input  logic [NUM_PORTS-1:0][$clog2(DEPTH)-1:0]   req_addr_i,
    input  logic [NUM_PORTS-1:0][WIDTH-1:0]           req_wdata_i,
    input  logic [NUM_PORTS-1:0][WIDTH/8-1:0]         req_be_i,
    output logic [NUM_PORTS-1:0]                      rsp_valid_o,
    output logic [NUM_PORTS-1:0][WIDTH-1:0]           rsp_rdata_o,
    output logic                                      init_done_o,
    output logic [31:0]                               conflict_cnt_o
);

    localparam int NB_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int NBY  = WIDTH / 8;

    if ((NUM_BANKS < 1) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_chk_nb
        $error("banked_mem: NUM_BANKS must be a power of 2");
    end
    if ((DEPTH % NUM_BANKS) != 0) begin : g_chk_depth
        $error("banked_mem: DEPTH must be a multiple of NUM_BANKS");
    end
    if ((WIDTH % 8) != 0) begin : g_chk_width
        $error("banked_mem: WIDTH must be a multiple of 8");
    end
    if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_chk_lat
        $error("banked_mem: READ_LAT must be 1 or 2");
    end

    // Word-linear storage: index == addr == row*NUM_BANKS + bank
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [NUM_BANKS-1:0][PW-1:0]        r_ptr;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] w_hit;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] w_gnt;
    logic [NUM_PORTS-1:0][NB_W-1:0]      w_bank;
    logic [NUM_PORTS-1:0]                w_gnt_p;
    logic [NUM_PORTS-1:0]                w_hs;
    logic                                w_init;
    logic                                w_run;
    logic                                w_conflict;
    logic                                w_clr;
    logic [31:0]                         r_cnt;
    logic [NUM_PORTS-1:0]                r_v1;
    logic [NUM_PORTS-1:0][WIDTH-1:0]     r_d1;
    logic [NUM_PORTS-1:0]                w_rv;
    logic [NUM_PORTS-1:0][WIDTH-1:0]     w_rd;

    function automatic logic [NUM_PORTS-1:0] f_pick(
        input logic [NUM_PORTS-1:0] hit,
        input logic [PW-1:0]        ptr
    );
        logic [NUM_PORTS-1:0] g;
        logic                 done;
        int                   idx;
        g    = '0;
        done = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (!done && hit[idx]) begin
                g[idx] = 1'b1;
                done   = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [PW-1:0] f_next(
        input logic [NUM_PORTS-1:0] g,
        input logic [PW-1:0]        ptr
    );
        logic [PW-1:0] n;
        n = ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (g[k]) n = PW'((k + 1) % NUM_PORTS);
        end
        return n;
    endfunction

    always_comb begin
        w_bank     = '0;
        w_hit      = '0;
        w_gnt      = '0;
        w_gnt_p    = '0;
        w_conflict = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_bank[p] = NB_W'(int'(req_addr_i[p]) % NUM_BANKS);
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                w_hit[b][p] = req_valid_i[p] && (int'(w_bank[p]) == b);
            end
            w_gnt[b] = f_pick(w_hit[b], r_ptr[b]);
            if ($countones(w_hit[b]) >= 2) w_conflict = 1'b1;
            w_gnt_p = w_gnt_p | w_gnt[b];
        end
    end

    assign w_run       = w_init & ~rst_i;
    assign req_ready_o = w_gnt_p & {NUM_PORTS{w_run}};
    assign w_hs        = req_ready_o;
    assign init_done_o = w_run;

`ifdef BANKED_MEM_CLEAR_EN
    localparam int ROWS = DEPTH / NUM_BANKS;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW   = $clog2(DEPTH);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_row_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_CLEAR;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_clr       = 1'b0;
        unique case (r_state)
            S_CLEAR: begin
                w_clr     = ~rst_i;
                w_row_nxt = r_row + 1'b1;
                if (r_row == RW'(ROWS - 1)) begin
                    w_state_nxt = S_RUN;
                    w_row_nxt   = '0;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    assign w_init = (r_state == S_RUN);
`else
    assign w_clr  = 1'b0;
    assign w_init = 1'b1;
`endif

    // Array has no reset; only the clear sweep and granted writes touch it
    always_ff @(posedge clk_i) begin
`ifdef BANKED_MEM_CLEAR_EN
        if (w_clr) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_mem[AW'(int'(r_row) * NUM_BANKS + b)] <= '0;
            end
        end
`endif
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_hs[p] && req_we_i[p]) begin
                for (int y = 0; y < NBY; y++) begin
                    if (req_be_i[p][y]) begin
                        r_mem[req_addr_i[p]][y*8 +: 8] <= req_wdata_i[p][y*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_run && (|w_gnt[b])) r_ptr[b] <= f_next(w_gnt[b], r_ptr[b]);
            end
            if (w_conflict && (r_cnt != 32'hFFFF_FFFF)) r_cnt <= r_cnt + 32'd1;
        end
    end

    assign conflict_cnt_o = rst_i ? 32'd0 : r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1 <= '0;
            r_d1 <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_v1[p] <= w_hs[p] & ~req_we_i[p];
                if (w_hs[p] && !req_we_i[p]) r_d1[p] <= r_mem[req_addr_i[p]];
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [NUM_PORTS-1:0]            r_v2;
        logic [NUM_PORTS-1:0][WIDTH-1:0] r_d2;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_v2 <= '0;
                r_d2 <= '0;
            end else begin
                r_v2 <= r_v1;
                r_d2 <= r_d1;
            end
        end

        assign w_rv = r_v2;
        assign w_rd = r_d2;
    end else begin : g_lat1
        assign w_rv = r_v1;
        assign w_rd = r_d1;
    end

    always_comb begin
        rsp_valid_o = w_rv & ~{NUM_PORTS{rst_i}};
        rsp_rdata_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_rdata_o[p] = rst_i ? '0 : w_rd[p];
        end
    end

endmodule

// File: tb/tb_banked_mem.sv
// Directed bench for banked_mem: one READ_LAT=1 and one READ_LAT=2 instance
// sharing stimulus; expected values are hand-computed constants.
module tb_banked_mem;

    logic             clk;
    logic             rst;
    logic [1:0]       vld;
    logic [1:0]       we;
    logic [1:0][5:0]  addr;
    logic [1:0][31:0] wd;
    logic [1:0][3:0]  be;

    logic [1:0]       rdy;
    logic [1:0]       rv;
    logic [1:0][31:0] rd;
    logic             init;
    logic [31:0]      cc;

    logic [1:0]       rdy2;
    logic [1:0]       rv2;
    logic [1:0][31:0] rd2;
    logic             init2;
    logic [31:0]      cc2;

    int n_chk;
    int n_fail;

    banked_mem #(
        .WIDTH(32), .DEPTH(64), .NUM_BANKS(4), .NUM_PORTS(2), .READ_LAT(1), .MEM_FILE("")
    ) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(vld), .req_ready_o(rdy), .req_we_i(we),
        .req_addr_i(addr), .req_wdata_i(wd), .req_be_i(be),
        .rsp_valid_o(rv), .rsp_rdata_o(rd),
        .init_done_o(init), .conflict_cnt_o(cc)
    );

    banked_mem #(
        .WIDTH(32), .DEPTH(64), .NUM_BANKS(4), .NUM_PORTS(2), .READ_LAT(2), .MEM_FILE("")
    ) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(vld), .req_ready_o(rdy2), .req_we_i(we),
        .req_addr_i(addr), .req_wdata_i(wd), .req_be_i(be),
        .rsp_valid_o(rv2), .rsp_rdata_o(rd2),
        .init_done_o(init2), .conflict_cnt_o(cc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input logic [5:0] a, input logic [31:0] d,
                      input logic [3:0] b);
        vld[p]  = 1'b1;
        we[p]   = 1'b1;
        addr[p] = a;
        wd[p]   = d;
        be[p]   = b;
        @(negedge clk);
        chk("wr_ready", 32'(rdy[p]), 32'd1);
        step();
        vld[p] = 1'b0;
        we[p]  = 1'b0;
    endtask

    task automatic rdchk(input string tag, input int p, input logic [5:0] a,
                         input logic [31:0] exp);
        vld[p]  = 1'b1;
        we[p]   = 1'b0;
        addr[p] = a;
        @(negedge clk);
        chk("rd_ready", 32'(rdy[p]), 32'd1);
        step();
        vld[p] = 1'b0;
        @(negedge clk);
        chk("rd_valid", 32'(rv), 32'(2'b01 << p));
        chk(tag, rd[p], exp);
        step();
    endtask

    task automatic wait_init(input int exp_lat);
        int n;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (init) break;
            n++;
        end
        if (!init) chk("init_timeout", 32'(init), 32'd1);
        chk("init_lat", 32'(n), 32'(exp_lat));
        step();
    endtask

    localparam int INIT_LAT =
`ifdef BANKED_MEM_CLEAR_EN
        16;
`else
        0;
`endif

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        vld    = 2'b11;
        we     = '0;
        addr   = '0;
        addr[1] = 6'd1;
        wd     = '0;
        be     = '0;

        // Reset state, with requests pending to prove ready is forced low
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_rsp", 32'(rv), 32'd0);
        chk("rst_rdata", rd[0], 32'd0);
        chk("rst_init", 32'(init), 32'd0);
        chk("rst_cnt", cc, 32'd0);
        step();
        vld = '0;
        rst = 1'b0;
        wait_init(INIT_LAT);

        // 1: write then read-after-write on another port
        wr(0, 6'd5, 32'hDEAD_BEEF, 4'hF);
        rdchk("raw_5", 1, 6'd5, 32'hDEAD_BEEF);

        // 2: byte enables, and all-zero be as a no-op
        wr(0, 6'd9, 32'h0000_0000, 4'hF);
        wr(0, 6'd9, 32'h1122_3344, 4'b0101);
        rdchk("be_9", 1, 6'd9, 32'h0022_0044);
        wr(0, 6'd9, 32'hFFFF_FFFF, 4'h0);
        rdchk("be0_9", 1, 6'd9, 32'h0022_0044);
        wr(1, 6'd1, 32'h0000_1111, 4'hF);
        chk("cnt_pre", cc, 32'd0);

        // 3: both ports on bank 1 for 4 cycles, alternating grants
        vld     = 2'b11;
        we      = 2'b00;
        addr[0] = 6'd1;
        addr[1] = 6'd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c > 0) begin
                chk("conf_rv", 32'(rv), ((c - 1) % 2 == 0) ? 32'd1 : 32'd2);
                chk("conf_rd", rd[(c - 1) % 2],
                    ((c - 1) % 2 == 0) ? 32'h0000_1111 : 32'hDEAD_BEEF);
            end
            if (c < 4) chk("conf_rdy", 32'(rdy), (c % 2 == 0) ? 32'd1 : 32'd2);
            step();
            if (c == 3) vld = 2'b00;
        end
        chk("conf_cnt", cc, 32'd4);

        // 4: different banks proceed together
        wr(0, 6'd0, 32'hA5A5_0000, 4'hF);
        vld     = 2'b11;
        addr[0] = 6'd0;
        addr[1] = 6'd1;
        @(negedge clk);
        chk("par_rdy", 32'(rdy), 32'd3);
        step();
        vld = 2'b00;
        @(negedge clk);
        chk("par_rv", 32'(rv), 32'd3);
        chk("par_rd0", rd[0], 32'hA5A5_0000);
        chk("par_rd1", rd[1], 32'h0000_1111);
        chk("par_cnt", cc, 32'd4);
        step();

        // 5: streamed reads, latency 1 and 2 side by side
        wr(0, 6'd2, 32'h0000_0022, 4'hF);
        wr(0, 6'd3, 32'h0000_0033, 4'hF);
        begin
            logic [31:0] img [4];
            img[0] = 32'hA5A5_0000;
            img[1] = 32'h0000_1111;
            img[2] = 32'h0000_0022;
            img[3] = 32'h0000_0033;
            for (int c = 0; c < 7; c++) begin
                vld[0]  = (c < 4);
                addr[0] = 6'(c % 4);
                @(negedge clk);
                if (c < 4) chk("str_rdy2", 32'(rdy2[0]), 32'd1);
                chk("str_rv1", 32'(rv[0]), (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
                if (c >= 1 && c <= 4) chk("str_rd1", rd[0], img[c - 1]);
                chk("str_rv2", 32'(rv2[0]), (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
                if (c >= 2 && c <= 5) chk("str_rd2", rd2[0], img[c - 2]);
                step();
            end
            vld = 2'b00;
        end

        // 6: reset right after a read accept drops the response
        vld[0]  = 1'b1;
        addr[0] = 6'd5;
        @(negedge clk);
        chk("drop_rdy", 32'(rdy[0]), 32'd1);
        step();
        vld = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        chk("drop_rv", 32'(rv), 32'd0);
        chk("drop_rv2", 32'(rv2), 32'd0);
        chk("drop_cnt", cc, 32'd0);
        chk("drop_init", 32'(init), 32'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rv", 32'(rv), 32'd0);
            chk("post_rv2", 32'(rv2), 32'd0);
            if (c < 2) step();
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_init(INIT_LAT);
        chk("post_cnt", cc, 32'd0);

`ifdef BANKED_MEM_CLEAR_EN
        for (int a = 0; a < 65; a++) begin
            vld[0]  = (a < 64);
            we[0]   = 1'b0;
            addr[0] = 6'(a % 64);
            @(negedge clk);
            if (a > 0) begin
                chk("clr_rv", 32'(rv[0]), 32'd1);
                chk("clr_rd", rd[0], 32'd0);
            end
            step();
        end
        vld = 2'b00;
`else
        rdchk("keep_5", 1, 6'd5, 32'hDEAD_BEEF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
